alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; successor to the two-op registered ALU in the riscvsingle datapath.
- Uses a valid/ready handshake on both sides, supports a wider operation set, and has full NZCV flags.
- MUL runs as an iterative shift-add sequence and back-pressures the producer while busy.
- Sits between the decode/operand stage and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of 2).
- MUL_ENABLE, 1, 1 = MUL implemented; 0 = MUL code treated as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op_in  in  4  operation code (encoding below).
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- out  out  WIDTH  result.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- N  out  1  negative flag.
- Z  out  1  zero flag.
- C  out  1  carry flag.
- V  out  1  overflow flag.
- err  out  1  illegal opcode flag (qualified by out_valid).

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: out=0, out_valid=0, N=0, Z=0, C=0, V=0, err=0, FSM=IDLE. Reset mid-MUL abandons the operation; no result is produced.
- Opcode encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL. Codes 11–15 are illegal (MUL is also illegal when MUL_ENABLE=0).
- Accept: a request is accepted on an edge where in_valid && in_ready. Operands and opcode are captured at accept.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational, and allows a new accept in the same cycle a result is consumed.
- Output register holds one entry:
  - out/flags/err stay stable while out_valid && !out_ready.
  - out_valid clears on the edge where out_ready=1, unless a new result loads on that same edge.
- FSM states: IDLE, MUL.
  - IDLE, accept non-MUL: result loads into the output register at the next edge. Latency is 1 (out_valid high in the cycle after accept). State stays IDLE.
  - IDLE, accept MUL: go to MUL. Clear a 2*WIDTH accumulator and an iteration counter. Shift register = a (zero-extended), multiplier = b.
  - MUL: each cycle, if multiplier[0], add shifted A to the accumulator; shift A left 1, multiplier right 1; counter+1.
  - MUL completes after WIDTH iterations: load the output and return to IDLE. out_valid rises WIDTH+1 cycles after accept. in_ready=0 throughout MUL.
  - MUL completion with output occupied and !out_ready: MUL cannot start then, because the in_ready rule guarantees the output is empty at MUL accept, and in_ready stays low until completion.
- Arithmetic rules (width WIDTH, wrap modulo 2^WIDTH):
  - ADD: {C,result} = a+b. V = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - SUB: {C,result} = a + ~b + 1, so C=1 means no borrow (a ≥ b unsigned). V = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
  - AND/OR/XOR: bitwise; C=0, V=0.
  - SLL/SRL/SRA: shift amount = b[$clog2(WIDTH)-1:0]; upper b bits are ignored. SRA sign-fills. C=0, V=0.
  - SLT: result = signed(a)<signed(b) ? 1 : 0. SLTU: unsigned compare. C=0, V=0.
  - MUL: result = low WIDTH bits of the unsigned product. C=0. V=1 iff the high WIDTH bits are nonzero.
  - All ops: N = result[WIDTH-1], Z = (result==0).
  - Illegal: result=0, err=1, N=0, Z=1, C=0, V=0, latency 1. err=0 for all legal ops.
- in_valid with in_ready=0: no capture; the producer must hold the request.

Test Plan:
- WIDTH=8: ADD a=0x7F, b=0x01, out_ready=1 → out_valid 1 cycle after accept, out=0x80, N=1, Z=0, C=0, V=1.
- WIDTH=8: SUB a=0x05, b=0x05 → out=0x00, Z=1, C=1, V=0. Then SUB a=0x00, b=0x01 → out=0xFF, N=1, C=0, V=0.
- WIDTH=8: SRA a=0x80, b=0x13 (amount 3) → out=0xF0. SLT a=0xFF, b=0x01 → 1. SLTU same operands → 0.
- WIDTH=8: MUL a=0x10, b=0x11 → in_ready=0 for 8 cycles, out_valid at accept+9, out=0x10, V=1. MUL 0x0F*0x03 → 0x2D, V=0.
- Backpressure: ADD 1+2 with out_ready=0 → out=3 held, in_ready=0. Raise out_ready with in_valid XOR 0x0F^0xF0 → consume and accept on the same edge; next cycle out=0xFF. Opcode 12 → err=1, out=0, Z=1.
- Reset asserted during MUL iteration 4 → next cycle out_valid=0, all flags 0, in_ready=1. A following ADD 2+2 returns 4 with latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, NZCV flags and an iterative shift-add MUL.
// Single-entry output register; MUL stalls the producer until its result loads.
module alu_mc #(
    parameter int WIDTH      = 32,
    parameter bit MUL_ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             err;
    } alu_res_t;

    // Single-cycle ops; MUL and codes 11-15 fall to the illegal path here.
    function automatic alu_res_t alu_eval(input logic [3:0]       op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        alu_res_t                r;
        logic [WIDTH:0]          sum;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          sh;
        r   = '0;
        sum = '0;
        sa  = a;
        sb  = b;
        sh  = b[SHW-1:0];
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                r.res = sum[WIDTH-1:0];
                r.c   = sum[WIDTH];
                r.v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                r.res = sum[WIDTH-1:0];
                r.c   = sum[WIDTH];
                r.v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_XOR:  r.res = a ^ b;
            OP_SLL:  r.res = a << sh;
            OP_SRL:  r.res = a >> sh;
            OP_SRA:  r.res = sa >>> sh;
            OP_SLT:  r.res = (sa < sb) ? WIDTH'(1) : '0;
            OP_SLTU: r.res = (a < b) ? WIDTH'(1) : '0;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               start_mul;
    logic               mul_done;
    alu_res_t           alu_p0;
    logic [2*WIDTH-1:0] acc_p1;
    logic [2*WIDTH-1:0] mcand_p1;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier_p1;
    logic [SHW-1:0]     cnt_p1;

    assign accept    = in_valid && in_ready;
    assign start_mul = accept && MUL_ENABLE && (op_in == OP_MUL);
    assign alu_p0    = alu_eval(op_in, a_in, b_in);
    assign acc_sum   = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
    assign mul_done  = (state == MUL) && (cnt_p1 == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mul) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accept-and-consume in the same cycle is allowed when the consumer drains the output.
    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
    end

    // MUL iteration stage: one partial product per cycle.
    always_ff @(posedge clk) begin
        if (start_mul) begin
            acc_p1    <= '0;
            mcand_p1  <= {{WIDTH{1'b0}}, a_in};
            mplier_p1 <= b_in;
            cnt_p1    <= '0;
        end else if (state == MUL) begin
            acc_p1    <= acc_sum;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
            cnt_p1    <= cnt_p1 + SHW'(1);
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            N         <= 1'b0;
            Z         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            err       <= 1'b0;
        end else if (accept && !start_mul) begin
            out       <= alu_p0.res;
            out_valid <= 1'b1;
            N         <= alu_p0.res[WIDTH-1];
            Z         <= (alu_p0.res == '0);
            C         <= alu_p0.c;
            V         <= alu_p0.v;
            err       <= alu_p0.err;
        end else if (mul_done) begin
            out       <= acc_sum[WIDTH-1:0];
            out_valid <= 1'b1;
            N         <= acc_sum[WIDTH-1];
            Z         <= (acc_sum[WIDTH-1:0] == '0);
            C         <= 1'b0;
            V         <= |acc_sum[2*WIDTH-1:WIDTH];
            err       <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8: arithmetic/flag vectors, MUL timing,
// backpressure with same-edge consume/accept, illegal opcodes and reset during MUL.
module tb_alu_mc;

    logic       clk;
    logic       reset;
    logic [3:0] op_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       N;
    logic       Z;
    logic       C;
    logic       V;
    logic       err;

    int errors = 0;
    int checks = 0;

    alu_mc #(.WIDTH(8), .MUL_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .N(N), .Z(Z), .C(C), .V(V), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge; caller guarantees in_ready.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        op_in    = op;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out); end
        checks++;
        if ({N, Z, C, V, err} !== 5'b00000) begin
            errors++; $display("FAIL reset_flags: NZCVerr got %b want 00000", {N, Z, C, V, err});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(4'd0, 8'h7F, 8'h01);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h80) begin
            errors++; $display("FAIL add_out: valid=%b out=%h want valid=1 out=80", out_valid, out);
        end
        checks++;
        if ({N, Z, C, V, err} !== 5'b10010) begin
            errors++; $display("FAIL add_flags: NZCVerr got %b want 10010", {N, Z, C, V, err});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        issue(4'd1, 8'h05, 8'h05);
        checks++;
        if (out !== 8'h00 || {N, Z, C, V, err} !== 5'b01100) begin
            errors++; $display("FAIL sub_eq: out=%h NZCVerr=%b want 00 01100", out, {N, Z, C, V, err});
        end
        issue(4'd1, 8'h00, 8'h01);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'hFF || {N, Z, C, V, err} !== 5'b10000) begin
            errors++; $display("FAIL sub_borrow: valid=%b out=%h NZCVerr=%b want 1 FF 10000",
                               out_valid, out, {N, Z, C, V, err});
        end
    endtask

    task automatic test_shift_cmp();
        out_ready = 1'b1;
        issue(4'd7, 8'h80, 8'h13);
        checks++;
        if (out !== 8'hF0 || {N, Z, C, V} !== 4'b1000) begin
            errors++; $display("FAIL sra: out=%h NZCV=%b want F0 1000", out, {N, Z, C, V});
        end
        issue(4'd6, 8'h80, 8'h0F);
        checks++;
        if (out !== 8'h01) begin errors++; $display("FAIL srl: got %h want 01", out); end
        issue(4'd5, 8'h81, 8'h01);
        checks++;
        if (out !== 8'h02 || C !== 1'b0) begin
            errors++; $display("FAIL sll: out=%h C=%b want 02 0", out, C);
        end
        issue(4'd8, 8'hFF, 8'h01);
        checks++;
        if (out !== 8'h01 || {N, Z} !== 2'b00) begin
            errors++; $display("FAIL slt: out=%h NZ=%b want 01 00", out, {N, Z});
        end
        issue(4'd9, 8'hFF, 8'h01);
        checks++;
        if (out !== 8'h00 || Z !== 1'b1) begin
            errors++; $display("FAIL sltu: out=%h Z=%b want 00 1", out, Z);
        end
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        tick();
        issue(4'd10, 8'h10, 8'h11);
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL mul_busy cycle %0d: in_ready=%b out_valid=%b want 0 0",
                                   i, in_ready, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h10) begin
            errors++; $display("FAIL mul_done: valid=%b out=%h want 1 10", out_valid, out);
        end
        checks++;
        if ({N, Z, C, V, err} !== 5'b00010) begin
            errors++; $display("FAIL mul_flags: NZCVerr got %b want 00010", {N, Z, C, V, err});
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready_after: got %b want 1", in_ready); end
        issue(4'd10, 8'h0F, 8'h03);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h2D || {N, Z, C, V} !== 4'b0000) begin
            errors++; $display("FAIL mul_small: valid=%b out=%h NZCV=%b want 1 2D 0000",
                               out_valid, out, {N, Z, C, V});
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        issue(4'd0, 8'h01, 8'h02);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h03 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_first: valid=%b out=%h ready=%b want 1 03 0",
                               out_valid, out, in_ready);
        end
        op_in    = 4'd4;
        a_in     = 8'h0F;
        b_in     = 8'hF0;
        in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h03 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold: valid=%b out=%h ready=%b want 1 03 0",
                               out_valid, out, in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out !== 8'hFF || {N, Z, C, V, err} !== 5'b10000) begin
            errors++; $display("FAIL bp_xor: valid=%b out=%h NZCVerr=%b want 1 FF 10000",
                               out_valid, out, {N, Z, C, V, err});
        end
        issue(4'd12, 8'h12, 8'h34);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h00 || {N, Z, C, V, err} !== 5'b01001) begin
            errors++; $display("FAIL illegal: valid=%b out=%h NZCVerr=%b want 1 00 01001",
                               out_valid, out, {N, Z, C, V, err});
        end
        issue(4'd2, 8'hF0, 8'h3C);
        checks++;
        if (out !== 8'h30 || err !== 1'b0) begin
            errors++; $display("FAIL and_after_illegal: out=%h err=%b want 30 0", out, err);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic seen_valid;
        out_ready = 1'b1;
        tick();
        issue(4'd10, 8'h10, 8'h11);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out !== 8'h00 || {N, Z, C, V, err} !== 5'b00000) begin
            errors++; $display("FAIL rst_mul_state: valid=%b out=%h NZCVerr=%b want 0 00 00000",
                               out_valid, out, {N, Z, C, V, err});
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul_ready: got %b want 1", in_ready); end
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin errors++; $display("FAIL rst_mul_abandon: got valid=%b want 0", seen_valid); end
        issue(4'd0, 8'h02, 8'h02);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h04 || {N, Z, C, V, err} !== 5'b00000) begin
            errors++; $display("FAIL rst_add: valid=%b out=%h NZCVerr=%b want 1 04 00000",
                               out_valid, out, {N, Z, C, V, err});
        end
    endtask

    initial begin
        reset     = 1'b1;
        op_in     = 4'd0;
        a_in      = 8'h00;
        b_in      = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_shift_cmp();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
